// File: rtl/freq_mult_pkg.sv
// Shared types and constants for the frequency-multiplier sequencer.
//   fmc_state_t : sequencer states
//   ERR_*       : err_code encodings
//   clamp_n     : limits the multiplier exponent to the configured maximum
package freq_mult_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_KC, LOAD, COUNT, ERR} fmc_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ZERO_K  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic [3:0] clamp_n(input logic [3:0] n, input logic [3:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/fmc_timeout_timer.sv
// Saturating watchdog counter for the sequencer.
//   clk, rst : clock, async active-high reset
//   en       : count this cycle
//   clr      : synchronous clear (wins over en)
//   expired  : count has reached TIMEOUT_CYC-1; holds there until cleared
module fmc_timeout_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && cnt != LAST)   cnt <= cnt + TW'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/freq_mult_ctrl.sv
// Sequencer for the frequency-multiplier datapath. After each rising edge of
// the datapath's kc flag it issues 2^(n_eff+1) reload/count bursts so the
// datapath output toggles 2^(n+1) times per cpu_clk period.
//   clk, rst       : clock, async active-high reset
//   start          : level run request; 0 returns to IDLE (and clears errors)
//   n              : multiplier exponent (clamped to MAX_N)
//   k              : datapath half-period measure; k>>1 == 0 is an error
//   kc, cout       : datapath status flags
//   counterEnable  : datapath count strobe
//   conterLoad     : datapath reload strobe
//   busy           : in WAIT_KC, LOAD or COUNT
//   err, err_code  : sticky error and its cause (01 zero k, 10 timeout)
//   locked         : two consecutive clean bursts seen
// Optional feature macro: FREQ_MULT_LOCK_DETECT_EN (lock detector; otherwise locked=0).
module freq_mult_ctrl
  import freq_mult_pkg::*;
#(
  parameter int MAX_N       = 7,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PW          = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n,
  input  logic [7:0] k,
  input  logic       kc,
  input  logic       cout,
  output logic       counterEnable,
  output logic       conterLoad,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic       locked
);

  fmc_state_t    state, state_n;
  logic          kc_d, kc_rise, expired;
  logic [PW-1:0] pcnt, pcnt_n, burst;
  logic [3:0]    n_eff, n_eff_n;
  logic [1:0]    code_n;

  assign kc_rise = kc & ~kc_d;
  // Burst length follows the exponent latched when the burst was started.
  assign burst   = PW'(1) << (n_eff + 4'd1);

  fmc_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .clr     (kc_rise | ~busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      kc_d     <= 1'b0;
      pcnt     <= '0;
      n_eff    <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_n;
      kc_d     <= kc;
      pcnt     <= pcnt_n;
      n_eff    <= n_eff_n;
      err_code <= code_n;
    end
  end

  // Priority: start=0 > zero-k > timeout > kc_rise (resync) > cout.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    n_eff_n = n_eff;
    code_n  = err_code;
    if (state != IDLE && state != ERR && !start) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_n = WAIT_KC;
        WAIT_KC: begin
          pcnt_n = '0;
          if (expired) begin
            state_n = ERR;
            code_n  = ERR_TIMEOUT;
          end else if (kc_rise) begin
            state_n = LOAD;
            n_eff_n = clamp_n(n, 4'(MAX_N));
          end
        end
        LOAD: begin
          if (k[7:1] == '0) begin
            state_n = ERR;
            code_n  = ERR_ZERO_K;
          end else if (expired) begin
            state_n = ERR;
            code_n  = ERR_TIMEOUT;
          end else if (kc_rise) begin
            pcnt_n  = '0;
          end else begin
            state_n = COUNT;
          end
        end
        COUNT: begin
          if (expired) begin
            state_n = ERR;
            code_n  = ERR_TIMEOUT;
          end else if (kc_rise) begin
            state_n = LOAD;
            pcnt_n  = '0;
          end else if (cout) begin
            pcnt_n  = pcnt + PW'(1);
            state_n = (pcnt_n == burst) ? WAIT_KC : LOAD;
          end
        end
        ERR: if (!start) begin
          state_n = IDLE;
          code_n  = ERR_NONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Strobes decode from state; the count strobe is suppressed on terminal count.
  assign conterLoad    = (state == LOAD);
  assign counterEnable = (state == COUNT) && !cout;
  assign busy          = (state == WAIT_KC) || (state == LOAD) || (state == COUNT);
  assign err           = (state == ERR);

`ifdef FREQ_MULT_LOCK_DETECT_EN
  logic [1:0] clean;
  logic       burst_done, resync;

  assign burst_done = (state == COUNT) && (state_n == WAIT_KC);
  // LOAD/COUNT -> LOAD on kc_rise is only ever the resync path.
  assign resync     = kc_rise && (state == LOAD || state == COUNT) && (state_n == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               clean <= '0;
    else if (resync || state_n == IDLE || state_n == ERR)  clean <= '0;
    else if (burst_done && clean != 2'd2)                  clean <= clean + 2'd1;
  end

  assign locked = (clean == 2'd2);
`else
  assign locked = 1'b0;
`endif

endmodule
